// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, oversampling factor and
// baud-generator limits for a 100 MHz system clock.
package uart_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam int unsigned OVERSAMPLE = 16;

  // limit = round(100 MHz / (16 * baud)); bits = counter width holding limit-1
  localparam int unsigned BR_LIMIT_9600   = 651;
  localparam int unsigned BR_BITS_9600    = 10;
  localparam int unsigned BR_LIMIT_19200  = 326;
  localparam int unsigned BR_BITS_19200   = 9;
  localparam int unsigned BR_LIMIT_115200 = 54;
  localparam int unsigned BR_BITS_115200  = 6;
  localparam int unsigned BR_LIMIT_1500   = 4167;
  localparam int unsigned BR_BITS_1500    = 13;

endpackage

// File: rtl/baud_rate_generator.sv
// Free-running modulo-M counter producing a one-cycle oversampling tick
// whenever the count reaches M-1.
module baud_rate_generator #(
  parameter int M = 651,
  parameter int N = 10
) (
  input  logic clk_100MHz,
  input  logic reset,
  output logic tick
);

  logic [N-1:0] r_cnt;
  logic         w_wrap;

  assign w_wrap = (r_cnt == N'(M - 1));

  always_ff @(posedge clk_100MHz) begin
    if (reset)       r_cnt <= '0;
    else if (w_wrap) r_cnt <= '0;
    else             r_cnt <= r_cnt + 1'b1;
  end

  assign tick = w_wrap;

endmodule

// File: rtl/uart_word_tx.sv
// Word-wide UART transmitter: sends a DBITS*NBYTES word as NBYTES back-to-back
// frames, most significant byte first. Define UART_WORD_TX_PARITY_EN for 8E1.
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int DBITS    = 8,
  parameter int NBYTES   = 8,
  parameter int SB_TICK  = 16,
  parameter int BR_LIMIT = 651,
  parameter int BR_BITS  = 10
) (
  input  logic                    clk_100MHz,
  input  logic                    reset,
  input  logic [DBITS*NBYTES-1:0] word_in,
  input  logic                    word_valid,
  output logic                    word_ready,
  output logic                    tx,
  output logic                    busy,
  output logic                    byte_done,
  output logic                    word_done
);

  localparam int WW  = DBITS * NBYTES;
  localparam int BYW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int BIW = (DBITS > 1) ? $clog2(DBITS) : 1;

  logic [2:0]       r_state;
  logic [WW-1:0]    r_shreg;
  logic [BYW-1:0]   r_byte_cnt;
  logic [BIW-1:0]   r_bit_cnt;
  logic [3:0]       r_tick_cnt;

  logic             w_tick;
  logic             w_bit_end;
  logic             w_stop_end;
  logic             w_last_byte;
  logic             w_accept;
  logic             w_tx;
  logic [DBITS-1:0] w_cur_byte;

  baud_rate_generator #(
    .M(BR_LIMIT),
    .N(BR_BITS)
  ) u_baud (
    .clk_100MHz(clk_100MHz),
    .reset     (reset),
    .tick      (w_tick)
  );

  // The byte on the wire always sits in the top of the shift register.
  assign w_cur_byte  = r_shreg[WW-1 -: DBITS];
  assign w_bit_end   = w_tick && (r_tick_cnt == 4'(OVERSAMPLE - 1));
  assign w_stop_end  = (r_state == STOP) && w_tick && (r_tick_cnt == 4'(SB_TICK - 1));
  assign w_last_byte = (r_byte_cnt == BYW'(NBYTES - 1));
  assign w_accept    = word_valid && word_ready;

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      r_state    <= IDLE;
      r_shreg    <= '0;
      r_byte_cnt <= '0;
      r_bit_cnt  <= '0;
      r_tick_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shreg    <= word_in;
            r_byte_cnt <= '0;
            r_tick_cnt <= '0;
            r_state    <= START;
          end
        end
        START: begin
          if (w_tick) r_tick_cnt <= r_tick_cnt + 4'd1;
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            r_state   <= DATA;
          end
        end
        DATA: begin
          if (w_tick) r_tick_cnt <= r_tick_cnt + 4'd1;
          if (w_bit_end) begin
            if (r_bit_cnt == BIW'(DBITS - 1)) begin
`ifdef UART_WORD_TX_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
`ifdef UART_WORD_TX_PARITY_EN
        PARITY: begin
          if (w_tick) r_tick_cnt <= r_tick_cnt + 4'd1;
          if (w_bit_end) r_state <= STOP;
        end
`endif
        STOP: begin
          if (w_stop_end) begin
            // explicit clear: SB_TICK below 16 would not wrap on its own
            r_tick_cnt <= '0;
            r_shreg    <= r_shreg << DBITS;
            if (w_last_byte) begin
              r_state <= IDLE;
            end else begin
              r_byte_cnt <= r_byte_cnt + 1'b1;
              r_state    <= START;
            end
          end else if (w_tick) begin
            r_tick_cnt <= r_tick_cnt + 4'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_tx = 1'b1;
    case (r_state)
      START:   w_tx = 1'b0;
      DATA:    w_tx = w_cur_byte[r_bit_cnt];
`ifdef UART_WORD_TX_PARITY_EN
      PARITY:  w_tx = ^w_cur_byte;
`endif
      default: w_tx = 1'b1;
    endcase
  end

  assign tx         = w_tx;
  assign word_ready = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  // Reset in the final stop-bit cycle must not leak a completion pulse.
  assign byte_done  = w_stop_end && !reset;
  assign word_done  = w_stop_end && w_last_byte && !reset;

endmodule

// File: tb/tb_uart_word_tx.sv
// Randomised bench for uart_word_tx: a line monitor decodes frames off tx and
// a bit-level waveform model checks run lengths, pulses and handshake timing.
module tb_uart_word_tx;

`ifdef UART_WORD_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int BP         = 64;              // 16 ticks x 4 clocks
  localparam int FB         = PAR ? 11 : 10;   // bits per frame
  localparam int WORD_BOUND = 8 * FB * BP + 400;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] word_in = '0;
  logic        word_valid = 1'b0;
  logic        word_ready, tx, busy, byte_done, word_done;

  int          n_vec = 0;
  int          n_err = 0;
  bit          mon_en = 1'b0;
  logic [9:0]  mon_q[$];
  int          exp_runs[$];

  uart_word_tx #(
    .DBITS   (8),
    .NBYTES  (8),
    .SB_TICK (16),
    .BR_LIMIT(4),
    .BR_BITS (2)
  ) dut (
    .clk_100MHz(clk),
    .reset     (reset),
    .word_in   (word_in),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .tx        (tx),
    .busy      (busy),
    .byte_done (byte_done),
    .word_done (word_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Line monitor: mid-bit sampling from the first low sample of each start bit.
  initial begin : uart_monitor
    logic       prev;
    logic [7:0] b;
    logic       p;
    logic       ferr;
    bit         live;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && prev && !tx) begin
        live = 1'b1; ferr = 1'b0; b = '0; p = 1'b0;
        repeat (BP / 2) @(negedge clk);
        if (tx !== 1'b0) ferr = 1'b1;
        for (int i = 0; i < 8; i++) begin
          repeat (BP) @(negedge clk);
          b[i] = tx;
          live &= mon_en;
        end
        if (PAR) begin
          repeat (BP) @(negedge clk);
          p = tx;
        end
        repeat (BP) @(negedge clk);
        if (tx !== 1'b1) ferr = 1'b1;
        live &= mon_en;
        if (live) mon_q.push_back({ferr, p, b});
      end
      prev = tx;
    end
  end

  // Expected line waveform as run lengths (in clocks), starting with the low start bit.
  task automatic build_runs(input logic [63:0] w);
    logic       bits[$];
    logic [7:0] b;
    bits = {};
    for (int i = 0; i < 8; i++) begin
      b = w[63 - 8 * i -: 8];
      bits.push_back(1'b0);
      for (int j = 0; j < 8; j++) bits.push_back(b[j]);
      if (PAR) bits.push_back(^b);
      bits.push_back(1'b1);
    end
    exp_runs = {};
    exp_runs.push_back(BP);
    for (int k = 1; k < bits.size(); k++) begin
      if (bits[k] == bits[k - 1]) exp_runs[exp_runs.size() - 1] += BP;
      else exp_runs.push_back(BP);
    end
  endtask

  task automatic check_bytes(input logic [63:0] w);
    logic [7:0] b;
    logic [9:0] e;
    chk("mon_count", 64'(mon_q.size()), 64'd8);
    for (int i = 0; i < 8 && i < mon_q.size(); i++) begin
      b = w[63 - 8 * i -: 8];
      e = {1'b0, (PAR ? ^b : 1'b0), b};
      chk("mon_byte", 64'(mon_q[i]), 64'(e));
    end
    mon_q.delete();
  endtask

  // pre: handshake already happened on the previous edge.
  // hold: keep word_valid high with nxt on word_in during transmission.
  task automatic run_word(input logic [63:0] w, input bit pre, input bit hold,
                          input logic [63:0] nxt);
    int   k, nbd, last_bd, cur_len;
    logic cur_lvl;
    int   got_runs[$];
    if (!pre) begin
      @(negedge clk);
      word_in    = w;
      word_valid = 1'b1;
      k = 0;
      while (!word_ready && k < WORD_BOUND) begin
        @(negedge clk);
        k++;
      end
      chk("accept_wait", 64'(k < WORD_BOUND), 64'd1);
    end
    @(negedge clk);
    if (hold) begin
      word_in = nxt;
    end else begin
      word_valid = 1'b0;
      word_in    = {$urandom, $urandom};
    end
    chk("accepted_state", 64'({tx, busy, word_ready}), 64'(3'b010));
    build_runs(w);
    cur_lvl = tx; cur_len = 1; nbd = 0; last_bd = 0; k = 0;
    got_runs = {};
    while (k < WORD_BOUND) begin
      @(negedge clk);
      k++;
      if (tx === cur_lvl) cur_len++;
      else begin
        got_runs.push_back(cur_len);
        cur_lvl = tx;
        cur_len = 1;
      end
      if (byte_done) begin
        nbd++;
        if (nbd > 1) chk("frame_len", 64'(k - last_bd), 64'(FB * BP));
        last_bd = k;
        chk("word_done_on_last", 64'(word_done), 64'(nbd == 8));
        if (word_done) break;
      end else if (word_done) begin
        chk("word_done_alone", 64'(word_done), 64'd0);
        break;
      end
    end
    chk("word_done_seen", 64'(k < WORD_BOUND), 64'd1);
    got_runs.push_back(cur_len);
    chk("byte_done_cnt", 64'(nbd), 64'd8);
    chk("run_count", 64'(got_runs.size()), 64'(exp_runs.size()));
    for (int i = 0; i < got_runs.size() && i < exp_runs.size(); i++) begin
      if (i == 0)
        chk("first_run", 64'(got_runs[0] >= exp_runs[0] - 3 && got_runs[0] <= exp_runs[0]), 64'd1);
      else
        chk("run_len", 64'(got_runs[i]), 64'(exp_runs[i]));
    end
    @(negedge clk);
    chk("ready_after_word", 64'({tx, busy, word_ready}), 64'(3'b101));
    check_bytes(w);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [63:0] wa, wb, wr;
    int          k, nbd, npulse, nbusy;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_hold", 64'({tx, word_ready, busy, byte_done, word_done}), 64'(5'b11000));
    reset  = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("reset_idle", 64'({tx, word_ready, busy, byte_done, word_done}), 64'(5'b11000));
    end

    run_word(64'h48454C4C4F212121, 1'b0, 1'b0, '0);

    wa = {$urandom, $urandom};
    wb = {$urandom, $urandom};
    run_word(wa, 1'b0, 1'b1, wb);
    run_word(wb, 1'b1, 1'b0, '0);

    run_word(64'hFF00FF00FF00FF00, 1'b0, 1'b0, '0);
    run_word(64'h0100000000000000, 1'b0, 1'b0, '0);

    // Reset during DATA of byte 3
    wr = {$urandom, $urandom};
    @(negedge clk);
    word_in    = wr;
    word_valid = 1'b1;
    @(negedge clk);
    word_valid = 1'b0;
    chk("rst_test_accept", 64'(busy), 64'd1);
    nbd = 0; k = 0;
    while (nbd < 3 && k < 4 * FB * BP) begin
      @(negedge clk);
      k++;
      if (byte_done) nbd++;
    end
    chk("rst_test_bytes", 64'(nbd), 64'd3);
    repeat (3 * BP) @(negedge clk);
    reset  = 1'b1;
    mon_en = 1'b0;
    @(negedge clk);
    chk("rst_mid_frame", 64'({tx, word_ready, busy, byte_done, word_done}), 64'(5'b11000));
    reset  = 1'b0;
    npulse = 0; nbusy = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (byte_done || word_done) npulse++;
      if (busy || !tx) nbusy++;
    end
    chk("rst_no_pulses", 64'(npulse), 64'd0);
    chk("rst_stays_idle", 64'(nbusy), 64'd0);
    mon_q.delete();
    mon_en = 1'b1;
    run_word({$urandom, $urandom}, 1'b0, 1'b0, '0);

    for (int i = 0; i < 3; i++) run_word({$urandom, $urandom}, 1'b0, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_word_tx.md
Name: uart_word_tx

Overview:
- 64-bit-word-to-serial UART transmitter: the send-side counterpart of the receive path, which packs 8 received ASCII bytes into one 64-bit word.
- Accepts one 64-bit word on a valid/ready handshake.
- Emits it as 8 consecutive 8N1 frames on `tx`, timed by 16x oversampling ticks.
- Sits between the SIMON encrypt/decrypt datapath and the host serial line; it is an alternative to the separate FIFO-plus-transmitter pair.

Parameters:
- DBITS, 8, data bits per frame.
- NBYTES, 8, bytes per word; word width = DBITS*NBYTES.
- SB_TICK, 16, oversampling ticks in the stop bit.
- BR_LIMIT, 651, baud generator count limit (9600 baud at 100 MHz).
- BR_BITS, 10, baud generator counter width.

Ports:
- clk_100MHz  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- word_in  input  64  word to send; byte 7 (bits 63:56) is sent first.
- word_valid  input  1  word_in is valid.
- word_ready  output  1  block is idle and can accept a word.
- tx  output  1  serial data out, idle high.
- busy  output  1  a word is in transmission.
- byte_done  output  1  one-cycle pulse at the end of each stop bit.
- word_done  output  1  one-cycle pulse at the end of the last stop bit.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-high, ports clk_100MHz / reset.
- Reset values: tx=1, word_ready=1, busy=0, byte_done=0, word_done=0; FSM=IDLE; all counters=0.
- Tick generation:
  - `tick` is a 1-cycle pulse, asserted when the baud counter equals BR_LIMIT-1; the counter then wraps to 0.
  - The counter free-runs from reset.
- Accept:
  - Handshake occurs on the edge where word_valid && word_ready.
  - On that edge: word_in is latched into the shift register, byte counter=0, tick counter=0, state goes to START.
  - On the next cycle: tx=0, busy=1, word_ready=0.
  - word_valid while busy is ignored; word_in changes after acceptance have no effect.
- FSM states:
  - IDLE: tx=1. Exits on handshake.
  - START: tx=0. After 16 ticks, go to DATA with bit counter=0.
  - DATA: tx = current byte bit[n], LSB first. Each bit lasts 16 ticks. After bit DBITS-1, go to STOP (or PARITY when the feature is enabled).
  - STOP: tx=1 for SB_TICK ticks. At the end, pulse byte_done and shift the word left by DBITS.
    - If byte counter = NBYTES-1: also pulse word_done, go to IDLE.
    - Otherwise: increment the byte counter and go to START.
- Framing and timing:
  - No idle gap between bytes of a word.
  - The first start bit may be short by up to one tick period, because the tick is free-running. This is accepted.
- Ready timing: word_ready returns to 1 on the cycle after word_done. The earliest next acceptance is that cycle.
- Tick counter: 4 bits, wraps 15→0 at each bit boundary; counts only on tick.
- Reset mid-frame: on the next edge, all outputs return to reset values and the partial word is discarded. No pulses are emitted.
- Totals (no parity): frame = (1+DBITS)*16 + SB_TICK ticks; word = NBYTES frames = 1280 ticks at the defaults.

Optional Feature:
- Macro: UART_WORD_TX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP.
  - It lasts 16 ticks with tx = XOR of the 8 data bits (even parity).
  - Frame = 8E1, 176 ticks per byte at the defaults.
- When undefined: the PARITY state and its logic are absent; frames are 8N1.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding localparams: IDLE, START, DATA, PARITY, STOP;
  - OVERSAMPLE=16;
  - default BR_LIMIT/BR_BITS values per baud rate (9600, 19200, 115200, 1500).
- Sub-module: instantiate the existing baud_rate_generator (parameters M=BR_LIMIT, N=BR_BITS) for `tick`.
- The FSM, shift register and counters stay in uart_word_tx.

Test Plan:
Run with BR_LIMIT=4, BR_BITS=2, so one tick every 4 clocks.
- Reset → tx=1, word_ready=1, busy=0, both pulses 0 for 20 cycles.
- Send word_in=0x48454C4C4F212121 ("HELLO!!!") → UART monitor decodes bytes 0x48,0x45,0x4C,0x4C,0x4F,0x21,0x21,0x21 in order; 8 byte_done pulses; 1 word_done coinciding with the 8th; each frame 160 ticks.
- Hold word_valid high with a different word during transmission → only the first word appears on tx; the second is accepted the cycle after word_done.
- Assert reset during the DATA state of byte 3 → next cycle tx=1, word_ready=1, busy=0; no byte_done for byte 3; a fresh word then sends cleanly.
- Send word_in=0xFF00FF00FF00FF00 → start bit low for exactly 64 clocks (allowing a first-bit shortfall ≤4 clocks); stop bit high for 64 clocks; no gap before the next start bit.
- With UART_WORD_TX_PARITY_EN, send 0x0100000000000000 → byte 0x01 has parity bit 1, byte 0x00 has parity bit 0; frame length 176 ticks.
